dp_scheduler: RTL and testbench

DP_SCHEDULER -- requirements
Module: dp_scheduler

---
 rtl/dp_sched_pkg.sv | 12 +
 rtl/dp_sched_if.sv | 19 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/dp_scheduler.sv | 99 +++++++++
 tb/tb_dp_scheduler.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/dp_sched_pkg.sv
// Shared types and widths for the shared-datapath scheduler.
package dp_sched_pkg;
  localparam int OP_W  = 5;
  localparam int RES_W = 10;

  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_e;

  // A one-requester build still needs a 1-bit id/pointer.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dp_sched_if.sv
// Requester and response handshake bundle for dp_scheduler.
interface dp_sched_if
  import dp_sched_pkg::*;
#(parameter int N_REQ = 4);
  localparam int ID_W = id_w(N_REQ);

  logic [N_REQ-1:0]      req_valid;
  logic [OP_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [RES_W-1:0]      rsp_data;

  modport master (output req_valid, req_data, rsp_ready,
                  input  req_ready, rsp_valid, rsp_id, rsp_data);
  modport slave  (input  req_valid, req_data, rsp_ready,
                  output req_ready, rsp_valid, rsp_id, rsp_data);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o
);
  logic found;
  int   idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dp_scheduler.sv
// Time-shares one combinational datapath among N_REQ requesters:
// accept one operand, hold it on dp_in for SETTLE cycles, then present the result.
module dp_scheduler
  import dp_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  dp_sched_if.slave        bus,
  output logic [OP_W-1:0]  dp_in,
  input  logic [RES_W-1:0] dp_out,
  output logic             busy
);
  localparam int ID_W = id_w(N_REQ);
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d, id_q, id_d, win_idx;
  logic [3:0]        cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d, win_op;
  logic [RES_W-1:0]  res_q, res_d;
  logic [N_REQ-1:0]  arb_req, gnt;
  logic              accept;

  // Only offer grants in IDLE and never while reset is asserted.
  assign arb_req = (state_q == IDLE && !rst) ? bus.req_valid : '0;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  assign bus.req_ready = gnt;
  assign accept        = |gnt;

  always_comb begin
    win_idx = '0;
    win_op  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_idx = ID_W'(i);
        win_op  = bus.req_data[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: if (accept) begin
        op_d    = win_op;
        id_d    = win_idx;
        ptr_d   = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        cnt_d   = CNT_INIT;
        state_d = ISSUE;
      end
      ISSUE: if (cnt_q == 4'd0) begin
        res_d   = dp_out;
        state_d = RESPOND;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESPOND: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == RESPOND);
  assign bus.rsp_id   = id_q;
  assign bus.rsp_data = res_q;
  assign dp_in        = op_q;
endmodule

// File: tb/tb_dp_scheduler.sv
// Bench for dp_scheduler: SETTLE=1 instance against a cycle-timed reference
// model, plus a directed SETTLE=3 instance.
module tb_dp_scheduler;
  import dp_sched_pkg::*;

  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dp_sched_if #(.N_REQ(4)) bus1 ();
  dp_sched_if #(.N_REQ(4)) bus3 ();

  logic [4:0] dpi1, dpi3;
  logic [9:0] dpo1, dpo3;
  logic       busy1, busy3;

  assign dpo1 = {dpi1, ~dpi1};
  assign dpo3 = {dpi3, ~dpi3};

  dp_scheduler #(.N_REQ(4), .SETTLE(S1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dp_in(dpi1), .dp_out(dpo1), .busy(busy1));
  dp_scheduler #(.N_REQ(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .dp_in(dpi3), .dp_out(dpo3), .busy(busy3));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ph = cycles since acceptance (-1 when idle).
  int         ph;
  int         m_ptr;
  logic [4:0] m_op;
  logic [1:0] m_id;
  logic [9:0] m_res;
  bit         m_clean;
  int         ids[$];
  logic [9:0] last_rsp;

  function automatic logic [3:0] rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      int i = (p + k) % 4;
      if (v[i]) return 4'(1 << i);
    end
    return 4'b0;
  endfunction

  task automatic model_reset();
    ph = -1; m_ptr = 0; m_op = '0; m_id = '0; m_res = '0; m_clean = 1'b1;
  endtask

  task automatic step(input logic r, input logic [3:0] v, input logic [19:0] d, input logic rr);
    logic [3:0] exp_rdy, g;
    int idx;
    @(negedge clk);
    rst = r; bus1.req_valid = v; bus1.req_data = d; bus1.rsp_ready = rr;
    #1;
    exp_rdy = (!r && ph < 0) ? rr_pick(v, m_ptr) : 4'b0;
    chk("req_ready", bus1.req_ready, exp_rdy);
    chk("busy", busy1, ph >= 0);
    chk("rsp_valid", bus1.rsp_valid, ph > S1);
    if (ph > S1) begin
      chk("rsp_id", bus1.rsp_id, m_id);
      chk("rsp_data", bus1.rsp_data, m_res);
      last_rsp = bus1.rsp_data;
      if (rr && !r) ids.push_back(int'(bus1.rsp_id));
    end
    if (ph >= 1 && ph <= S1) chk("dp_in", dpi1, m_op);
    if (m_clean) begin
      chk("rst_dp_in", dpi1, 0);
      chk("rst_rsp_id", bus1.rsp_id, 0);
      chk("rst_rsp_data", bus1.rsp_data, 0);
    end
    @(posedge clk);
    if (r) model_reset();
    else if (ph < 0) begin
      g = rr_pick(v, m_ptr);
      if (g != 4'b0) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        m_op = d[idx*5 +: 5];
        m_id = 2'(idx);
        m_ptr = (idx + 1) % 4;
        ph = 1;
        m_clean = 1'b0;
      end
    end
    else if (ph < S1) ph++;
    else if (ph == S1) begin m_res = {m_op, ~m_op}; ph++; end
    else if (rr) ph = -1;
  endtask

  initial begin
    logic [31:0] fair_exp [5];
    fair_exp = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    bus1.req_valid = '0; bus1.req_data = '0; bus1.rsp_ready = 1'b0;
    bus3.req_valid = '0; bus3.req_data = '0; bus3.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Single op, data 3 -> {00011, 11100}
    step(0, 4'b0001, 20'h00003, 1);
    step(0, 4'b0000, 20'h0, 1);
    step(0, 4'b0000, 20'h0, 1);
    chk("single_data", last_rsp, 10'h07C);
    step(0, 4'b0000, 20'h0, 1);

    // Fairness from pointer 0, data i = i+1
    step(1, 4'b0000, 20'h0, 1);
    ids.delete();
    for (int k = 0; k < 15; k++) step(0, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, 1);
    for (int k = 0; k < 5; k++)
      chk("fair_id", (k < ids.size()) ? 32'(ids[k]) : 32'hFF, fair_exp[k]);

    // Backpressure: held response must stay stable with no grants
    step(0, 4'b0000, 20'h0, 1);
    step(0, 4'b0010, 20'($urandom), 1);
    for (int k = 0; k < 7; k++) step(0, 4'($urandom), 20'($urandom), 0);
    step(0, 4'b0000, 20'h0, 1);
    step(0, 4'b0000, 20'h0, 1);

    // Reset mid-op, then requester 2 alone
    step(0, 4'b0001, 20'h0001A, 1);
    step(1, 4'b0000, 20'h0, 1);
    step(0, 4'b0100, 20'h07C00, 1);
    for (int k = 0; k < 3; k++) step(0, 4'b0000, 20'h0, 1);

    // Withdraw: requester 1 asserts only while busy
    step(0, 4'b0001, 20'h00011, 1);
    step(0, 4'b0010, 20'h0, 0);
    step(0, 4'b0010, 20'h0, 0);
    step(0, 4'b0000, 20'h0, 1);
    step(0, 4'b0000, 20'h0, 1);
    chk("withdraw_last_id", ids[$], 0);

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 39) == 0), 4'($urandom), 20'($urandom),
           ($urandom_range(0, 3) != 0));
    for (int k = 0; k < 4; k++) step(0, 4'b0000, 20'h0, 1);

    // SETTLE=3 instance
    @(negedge clk);
    bus3.req_valid = 4'b0001; bus3.req_data = 20'h0001F; bus3.rsp_ready = 1'b1;
    #1 chk("s3_ready", bus3.req_ready, 4'b0001);
    @(negedge clk);
    bus3.req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("s3_dp_in", dpi3, 5'h1F);
      chk("s3_rsp_valid_lo", bus3.rsp_valid, 0);
      chk("s3_busy", busy3, 1);
      @(negedge clk);
    end
    #1;
    chk("s3_rsp_valid", bus3.rsp_valid, 1);
    chk("s3_rsp_data", bus3.rsp_data, 10'h3E0);
    chk("s3_rsp_id", bus3.rsp_id, 0);
    @(negedge clk);
    #1 chk("s3_idle", busy3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
